time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL provide parameter HOUR_MAX, default 23, meaning the largest legal hour value.
REQ-002 SHALL provide parameter MIN_MAX, default 59, meaning the largest legal minute value.
REQ-003 SHALL provide parameter SEC_MAX, default 59, meaning the largest legal second value.
REQ-004 SHALL have port clk  in  1  sole clock, rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port En  in  1  block enable; when low, state and registers hold.
REQ-007 SHALL have port set_mode  in  1  level; high requests time-set mode.
REQ-008 SHALL have ports btn_next, btn_inc, btn_dec, submit  in  1 each  synchronous button levels; only rising edges act.
REQ-009 SHALL have ports cur_hour, cur_min, cur_sec  in  7 each  running time, preloaded on entry.
REQ-010 SHALL have port wr_en  out  1  one-cycle write strobe to the time counter.
REQ-011 SHALL have port selout  out  2  write target: 00 sec, 01 min, 10 hour (11 never driven).
REQ-012 SHALL have port Dout  out  7  write data, valid only while wr_en=1, else 0.
REQ-013 SHALL have port editing  out  1  high in LOAD and EDIT states.
REQ-014 SHALL have port field  out  2  field under edit, same encoding as selout.

Function
REQ-015 SHALL implement states IDLE, LOAD, EDIT, WR_H, WR_M, WR_S.
REQ-016 SHALL register previous value of each button every clock when En=1; edge = current & ~previous.
REQ-017 SHALL hold all state, edge registers and outputs when En=0; edges spanning an En=0 interval are not lost or duplicated.
REQ-018 IDLE: set_mode=1 -> LOAD next cycle; otherwise stay.
REQ-019 LOAD: capture cur_hour/min/sec into edit registers, set field=10 (hour), -> EDIT; one cycle.
REQ-020 EDIT priority per cycle: set_mode=0 (abort) > submit edge > btn_next edge > inc/dec edges.
REQ-021 Abort SHALL return to IDLE with no write strobe; edit registers discarded.
REQ-022 submit edge SHALL go to WR_H.
REQ-023 btn_next edge SHALL advance field hour -> min -> sec -> hour (10 -> 01 -> 00 -> 10).
REQ-024 btn_inc edge alone: selected value +1; value at its MAX wraps to 0.
REQ-025 btn_dec edge alone: selected value -1; value 0 wraps to its MAX.
REQ-026 btn_inc and btn_dec edges in the same cycle SHALL leave the value unchanged.
REQ-027 Preloaded values exceeding MAX SHALL be clamped to MAX in LOAD.
REQ-028 WR_H, WR_M, WR_S SHALL each last one cycle, driving wr_en=1, selout=10/01/00 and Dout=edited hour/min/sec, then WR_S -> IDLE.
REQ-029 Write sequence SHALL not be interrupted by set_mode or buttons; submit-to-first-strobe latency is 1 cycle.
REQ-030 From IDLE, re-entry requires set_mode=1 again; a set_mode held high re-enters LOAD after WR_S.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE, wr_en=0, selout=00, Dout=0, editing=0, field=10, edit registers and button-history registers 0, regardless of En.
REQ-032 Reset mid-EDIT or mid-write SHALL abandon the operation with no further strobes.

Structure
REQ-033 SHALL place the state enumeration, selout codes and default MAX constants in shared package time_set_pkg.
REQ-034 SHALL use one sub-module, rise_detect (1-bit registered rising-edge detector with enable and synchronous reset), instantiated per button.

Verification
REQ-035 Enter, cur=12:34:56, submit -> strobes (10,12),(01,34),(00,56) on 3 consecutive cycles, then IDLE.
REQ-036 cur hour=23, btn_inc edge, submit -> first strobe Dout=0; cur sec=0, two btn_next, btn_dec, submit -> third strobe Dout=59.
REQ-037 btn_inc and btn_dec rising together on minute=30 -> minute strobe Dout=30.
REQ-038 In EDIT, drop set_mode with submit rising same cycle -> IDLE, no wr_en ever.
REQ-039 Hold btn_inc high 10 cycles -> exactly one increment; En=0 during a rising edge then En=1 -> exactly one increment.
REQ-040 rst_n=0 during WR_M -> no WR_S strobe, all outputs at reset values next cycle.

Source files
------------

// File: rtl/time_set_pkg.sv
// -----------------------------------------------------------------------------
// time_set_pkg
// Shared definitions for the time-set controller:
//   - state_t          : controller state enumeration
//   - SEL_*            : field / write-target codes (shared by selout and field)
//   - *_MAX_DEF        : default largest legal hour/minute/second values
//   - BTN_*            : bit positions of the buttons in the packed button bus
//   - next_field()     : field rotation hour -> min -> sec -> hour
//   - step_value()     : wrap-around increment/decrement of one field
//   - clamp_value()    : limit a preloaded value to its legal maximum
// -----------------------------------------------------------------------------
package time_set_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_EDIT = 3'd2,
      ST_WR_H = 3'd3,
      ST_WR_M = 3'd4,
      ST_WR_S = 3'd5
   } state_t;

   localparam logic [1:0] SEL_SEC  = 2'b00;
   localparam logic [1:0] SEL_MIN  = 2'b01;
   localparam logic [1:0] SEL_HOUR = 2'b10;

   localparam int HOUR_MAX_DEF = 23;
   localparam int MIN_MAX_DEF  = 59;
   localparam int SEC_MAX_DEF  = 59;

   localparam int BTN_NEXT   = 0;
   localparam int BTN_INC    = 1;
   localparam int BTN_DEC    = 2;
   localparam int BTN_SUBMIT = 3;
   localparam int NUM_BTN    = 4;

   // Edit order is hour first, then minute, then second, then back to hour.
   function automatic logic [1:0] next_field(input logic [1:0] f);
      logic [1:0] r;
      case (f)
         SEL_HOUR: r = SEL_MIN;
         SEL_MIN:  r = SEL_SEC;
         default:  r = SEL_HOUR;
      endcase
      return r;
   endfunction

   // Simultaneous inc and dec cancel out, leaving the value untouched.
   function automatic logic [6:0] step_value(input logic [6:0] v,
                                             input logic [6:0] vmax,
                                             input logic       inc,
                                             input logic       dec);
      logic [6:0] r;
      r = v;
      if (inc && !dec) begin
         r = (v >= vmax) ? 7'd0 : v + 7'd1;
      end else if (dec && !inc) begin
         r = (v == 7'd0) ? vmax : v - 7'd1;
      end
      return r;
   endfunction

   function automatic logic [6:0] clamp_value(input logic [6:0] v,
                                              input logic [6:0] vmax);
      return (v > vmax) ? vmax : v;
   endfunction

endpackage

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// One-bit registered rising-edge detector.
//   clk    in  : clock, rising edge
//   rst_n  in  : synchronous active-low reset, clears the history register
//   en     in  : history only advances while high; rise is suppressed while low
//   d      in  : synchronous level to watch
//   rise   out : d & ~previous(d), combinational from d and the history
// Because the history freezes while en is low, a rising edge that arrives
// during a disabled interval is still reported once enable returns.
// -----------------------------------------------------------------------------
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic d,
   output logic rise
);

   logic r_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prev <= 1'b0;
      end else if (en) begin
         r_prev <= d;
      end
   end

   assign rise = en & d & ~r_prev;

endmodule

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
// Lets a user edit hour/minute/second with next/inc/dec buttons and then
// writes the edited time to the time counter as three single-cycle strobes
// (hour, minute, second on consecutive cycles).
// Parameters:
//   HOUR_MAX, MIN_MAX, SEC_MAX : largest legal value of each field
// Ports:
//   clk        in  : clock, rising edge
//   rst_n      in  : synchronous active-low reset (wins over En)
//   En         in  : block enable; everything holds while low
//   set_mode   in  : level, high requests / keeps time-set mode
//   btn_next   in  : rising edge selects the next field
//   btn_inc    in  : rising edge increments the selected field
//   btn_dec    in  : rising edge decrements the selected field
//   submit     in  : rising edge starts the write sequence
//   cur_hour/cur_min/cur_sec in [6:0] : running time, preloaded on entry
//   wr_en      out : one-cycle write strobe
//   selout     out [1:0] : write target 00 sec, 01 min, 10 hour
//   Dout       out [6:0] : write data, zero when wr_en is low
//   editing    out : high in LOAD and EDIT
//   field      out [1:0] : field currently under edit
// -----------------------------------------------------------------------------
module time_set_ctrl
   import time_set_pkg::*;
#(
   parameter int HOUR_MAX = HOUR_MAX_DEF,
   parameter int MIN_MAX  = MIN_MAX_DEF,
   parameter int SEC_MAX  = SEC_MAX_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       En,
   input  logic       set_mode,
   input  logic       btn_next,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic       submit,
   input  logic [6:0] cur_hour,
   input  logic [6:0] cur_min,
   input  logic [6:0] cur_sec,
   output logic       wr_en,
   output logic [1:0] selout,
   output logic [6:0] Dout,
   output logic       editing,
   output logic [1:0] field
);

   localparam logic [6:0] HOUR_MAX_V = 7'(HOUR_MAX);
   localparam logic [6:0] MIN_MAX_V  = 7'(MIN_MAX);
   localparam logic [6:0] SEC_MAX_V  = 7'(SEC_MAX);

   // ------------------------------------------------------------------
   // Button edge detection, one detector per button
   // ------------------------------------------------------------------
   logic [NUM_BTN-1:0] w_btn;
   logic [NUM_BTN-1:0] w_rise;

   assign w_btn[BTN_NEXT]   = btn_next;
   assign w_btn[BTN_INC]    = btn_inc;
   assign w_btn[BTN_DEC]    = btn_dec;
   assign w_btn[BTN_SUBMIT] = submit;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         rise_detect u_rise (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (En),
            .d    (w_btn[gi]),
            .rise (w_rise[gi])
         );
      end
   endgenerate

   logic w_next_rise;
   logic w_inc_rise;
   logic w_dec_rise;
   logic w_submit_rise;

   assign w_next_rise   = w_rise[BTN_NEXT];
   assign w_inc_rise    = w_rise[BTN_INC];
   assign w_dec_rise    = w_rise[BTN_DEC];
   assign w_submit_rise = w_rise[BTN_SUBMIT];

   // ------------------------------------------------------------------
   // State and edit registers
   // ------------------------------------------------------------------
   state_t     r_state;
   state_t     w_state_next;
   logic [1:0] r_field;
   logic [1:0] w_field_next;
   logic [6:0] r_hour;
   logic [6:0] w_hour_next;
   logic [6:0] r_min;
   logic [6:0] w_min_next;
   logic [6:0] r_sec;
   logic [6:0] w_sec_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_field <= SEL_HOUR;
         r_hour  <= 7'd0;
         r_min   <= 7'd0;
         r_sec   <= 7'd0;
      end else if (En) begin
         r_state <= w_state_next;
         r_field <= w_field_next;
         r_hour  <= w_hour_next;
         r_min   <= w_min_next;
         r_sec   <= w_sec_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_field_next = r_field;
      w_hour_next  = r_hour;
      w_min_next   = r_min;
      w_sec_next   = r_sec;

      case (r_state)
         ST_IDLE: begin
            if (set_mode) begin
               w_state_next = ST_LOAD;
            end
         end

         ST_LOAD: begin
            w_hour_next  = clamp_value(cur_hour, HOUR_MAX_V);
            w_min_next   = clamp_value(cur_min, MIN_MAX_V);
            w_sec_next   = clamp_value(cur_sec, SEC_MAX_V);
            w_field_next = SEL_HOUR;
            w_state_next = ST_EDIT;
         end

         ST_EDIT: begin
            // Priority: abort, then submit, then field select, then inc/dec.
            if (!set_mode) begin
               w_state_next = ST_IDLE;
            end else if (w_submit_rise) begin
               w_state_next = ST_WR_H;
            end else if (w_next_rise) begin
               w_field_next = next_field(r_field);
            end else begin
               case (r_field)
                  SEL_HOUR: w_hour_next = step_value(r_hour, HOUR_MAX_V,
                                                     w_inc_rise, w_dec_rise);
                  SEL_MIN:  w_min_next  = step_value(r_min, MIN_MAX_V,
                                                     w_inc_rise, w_dec_rise);
                  default:  w_sec_next  = step_value(r_sec, SEC_MAX_V,
                                                     w_inc_rise, w_dec_rise);
               endcase
            end
         end

         // The write sequence ignores set_mode and buttons until it completes.
         ST_WR_H: w_state_next = ST_WR_M;
         ST_WR_M: w_state_next = ST_WR_S;
         ST_WR_S: w_state_next = ST_IDLE;

         default: w_state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs, decoded from the registered state so they hold with En low
   // ------------------------------------------------------------------
   always_comb begin
      wr_en   = 1'b0;
      selout  = SEL_SEC;
      Dout    = 7'd0;
      editing = 1'b0;
      field   = r_field;

      case (r_state)
         ST_LOAD, ST_EDIT: begin
            editing = 1'b1;
         end
         ST_WR_H: begin
            wr_en  = 1'b1;
            selout = SEL_HOUR;
            Dout   = r_hour;
         end
         ST_WR_M: begin
            wr_en  = 1'b1;
            selout = SEL_MIN;
            Dout   = r_min;
         end
         ST_WR_S: begin
            wr_en  = 1'b1;
            selout = SEL_SEC;
            Dout   = r_sec;
         end
         default: begin
            wr_en = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
// Self-checking bench for time_set_ctrl: directed scenarios plus randomized
// edit sessions predicted by a field-level arithmetic model.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       En;
   logic       set_mode;
   logic       btn_next;
   logic       btn_inc;
   logic       btn_dec;
   logic       submit;
   logic [6:0] cur_hour;
   logic [6:0] cur_min;
   logic [6:0] cur_sec;
   logic       wr_en;
   logic [1:0] selout;
   logic [6:0] Dout;
   logic       editing;
   logic [1:0] field;

   always #5 clk = ~clk;

   time_set_ctrl #(
      .HOUR_MAX(23),
      .MIN_MAX (59),
      .SEC_MAX (59)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .En      (En),
      .set_mode(set_mode),
      .btn_next(btn_next),
      .btn_inc (btn_inc),
      .btn_dec (btn_dec),
      .submit  (submit),
      .cur_hour(cur_hour),
      .cur_min (cur_min),
      .cur_sec (cur_sec),
      .wr_en   (wr_en),
      .selout  (selout),
      .Dout    (Dout),
      .editing (editing),
      .field   (field)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   typedef struct {
      logic [1:0] sel;
      logic [6:0] d;
      int         c;
   } strobe_t;

   strobe_t sq[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor: records every write the DUT issues.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         strobe_t s;
         s.sel = selout;
         s.d   = Dout;
         s.c   = cyc;
         sq.push_back(s);
      end
   end

   // Reference model: values per field index (0 hour, 1 min, 2 sec).
   int m_val[3];
   int m_fld;
   int m_max[3] = '{23, 59, 59};

   function automatic logic [1:0] sel_of(input int f);
      if (f == 0) return 2'b10;
      if (f == 1) return 2'b01;
      return 2'b00;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Enter edit mode from IDLE and seed the model.
   task automatic enter(input int h, input int m, input int s);
      cur_hour = 7'(h);
      cur_min  = 7'(m);
      cur_sec  = 7'(s);
      set_mode = 1'b1;
      ticks(2);
      m_val[0] = (h > m_max[0]) ? m_max[0] : h;
      m_val[1] = (m > m_max[1]) ? m_max[1] : m;
      m_val[2] = (s > m_max[2]) ? m_max[2] : s;
      m_fld    = 0;
      n_checks++;
      if (editing !== 1'b1 || field !== 2'b10)
         $display("FAIL enter: editing=%b field=%b, required editing=1 field=10",
                  editing, field);
      else n_pass++;
   endtask

   // One button press: mask bit0 next, bit1 inc, bit2 dec.
   task automatic press(input logic [2:0] mask);
      btn_next = mask[0];
      btn_inc  = mask[1];
      btn_dec  = mask[2];
      tick();
      btn_next = 1'b0;
      btn_inc  = 1'b0;
      btn_dec  = 1'b0;
      tick();
   endtask

   // Submit and verify the three strobes, their order, timing and data.
   task automatic submit_expect(input string name, input int eh, input int em,
                                input int es);
      int c0;
      int exp_d[3];
      logic [1:0] exp_s[3];
      exp_d = '{eh, em, es};
      exp_s = '{2'b10, 2'b01, 2'b00};
      sq.delete();
      c0 = cyc;
      submit = 1'b1;
      tick();
      set_mode = 1'b0;
      submit   = 1'b0;
      ticks(7);
      n_checks++;
      if (sq.size() != 3) begin
         $display("FAIL %s strobe count: got %0d, required 3", name, sq.size());
      end else begin
         n_pass++;
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (sq[k].sel !== exp_s[k] || sq[k].d !== 7'(exp_d[k]) ||
                sq[k].c != c0 + 1 + k)
               $display("FAIL %s strobe %0d: sel=%b d=%0d cyc=%0d, required sel=%b d=%0d cyc=%0d",
                        name, k, sq[k].sel, sq[k].d, sq[k].c, exp_s[k],
                        exp_d[k], c0 + 1 + k);
            else n_pass++;
         end
      end
      n_checks++;
      if (editing !== 1'b0 || wr_en !== 1'b0 || Dout !== 7'd0)
         $display("FAIL %s idle after write: editing=%b wr_en=%b Dout=%0d, required 0 0 0",
                  name, editing, wr_en, Dout);
      else n_pass++;
      $display("txn %s: expected %0d:%0d:%0d, strobes seen %0d", name, eh, em,
               es, sq.size());
   endtask

   task automatic test_reset();
      rst_n = 1'b0; En = 1'b0; set_mode = 1'b0;
      btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; submit = 1'b0;
      cur_hour = 7'd0; cur_min = 7'd0; cur_sec = 7'd0;
      ticks(3);
      n_checks++;
      if (wr_en !== 1'b0 || selout !== 2'b00 || Dout !== 7'd0 ||
          editing !== 1'b0 || field !== 2'b10)
         $display("FAIL reset: wr_en=%b selout=%b Dout=%0d editing=%b field=%b, required 0 00 0 0 10",
                  wr_en, selout, Dout, editing, field);
      else n_pass++;
      rst_n = 1'b1;
      En    = 1'b1;
      ticks(2);
      $display("txn reset done");
   endtask

   task automatic test_basic();
      enter(12, 34, 56);
      submit_expect("basic", 12, 34, 56);
   endtask

   task automatic test_wrap();
      enter(23, 10, 0);
      press(3'b010);
      press(3'b001);
      press(3'b001);
      n_checks++;
      if (field !== 2'b00)
         $display("FAIL wrap field: got %b, required 00", field);
      else n_pass++;
      press(3'b100);
      submit_expect("wrap", 0, 10, 59);
   endtask

   task automatic test_inc_dec_same();
      enter(5, 30, 7);
      press(3'b001);
      press(3'b110);
      n_checks++;
      if (field !== 2'b01)
         $display("FAIL incdec field: got %b, required 01", field);
      else n_pass++;
      submit_expect("incdec", 5, 30, 7);
   endtask

   task automatic test_clamp();
      enter(100, 77, 127);
      submit_expect("clamp", 23, 59, 59);
   endtask

   task automatic test_abort();
      enter(1, 2, 3);
      sq.delete();
      set_mode = 1'b0;
      submit   = 1'b1;
      tick();
      submit = 1'b0;
      ticks(6);
      n_checks++;
      if (sq.size() != 0 || editing !== 1'b0)
         $display("FAIL abort: strobes=%0d editing=%b, required 0 0",
                  sq.size(), editing);
      else n_pass++;
      $display("txn abort: strobes seen %0d", sq.size());
   endtask

   task automatic test_hold();
      enter(3, 4, 5);
      btn_inc = 1'b1;
      ticks(10);
      btn_inc = 1'b0;
      tick();
      submit_expect("hold", 4, 4, 5);

      enter(3, 4, 5);
      En      = 1'b0;
      btn_inc = 1'b1;
      ticks(3);
      n_checks++;
      if (editing !== 1'b1 || field !== 2'b10 || wr_en !== 1'b0)
         $display("FAIL en_hold: editing=%b field=%b wr_en=%b, required 1 10 0",
                  editing, field, wr_en);
      else n_pass++;
      En = 1'b1;
      ticks(3);
      btn_inc = 1'b0;
      tick();
      submit_expect("en_gap", 4, 4, 5);
   endtask

   task automatic test_reset_mid_write();
      enter(1, 2, 3);
      sq.delete();
      submit = 1'b1;
      tick();
      submit = 1'b0;
      tick();
      n_checks++;
      if (wr_en !== 1'b1 || selout !== 2'b01 || Dout !== 7'd2)
         $display("FAIL mid_write WR_M: wr_en=%b selout=%b Dout=%0d, required 1 01 2",
                  wr_en, selout, Dout);
      else n_pass++;
      rst_n    = 1'b0;
      set_mode = 1'b0;
      tick();
      n_checks++;
      if (wr_en !== 1'b0 || selout !== 2'b00 || Dout !== 7'd0 ||
          editing !== 1'b0 || field !== 2'b10)
         $display("FAIL mid_write reset: wr_en=%b selout=%b Dout=%0d editing=%b field=%b, required 0 00 0 0 10",
                  wr_en, selout, Dout, editing, field);
      else n_pass++;
      rst_n = 1'b1;
      ticks(5);
      n_checks++;
      if (sq.size() != 2)
         $display("FAIL mid_write strobes: got %0d, required 2", sq.size());
      else n_pass++;
      $display("txn reset_mid_write: strobes seen %0d", sq.size());
   endtask

   task automatic test_reenter();
      int  n;
      enter(7, 8, 9);
      sq.delete();
      submit = 1'b1;
      tick();
      submit = 1'b0;
      n = 0;
      while (editing !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      n_checks++;
      if (editing !== 1'b1 || sq.size() != 3 || field !== 2'b10)
         $display("FAIL reenter: editing=%b strobes=%0d field=%b, required 1 3 10",
                  editing, sq.size(), field);
      else n_pass++;
      set_mode = 1'b0;
      ticks(3);
      $display("txn reenter: strobes seen %0d, cycles to re-entry %0d",
               sq.size(), n);
   endtask

   task automatic test_random();
      for (int it = 0; it < 25; it++) begin
         int nops;
         enter($urandom_range(0, 127), $urandom_range(0, 127),
               $urandom_range(0, 127));
         nops = $urandom_range(1, 12);
         for (int k = 0; k < nops; k++) begin
            int op;
            op = $urandom_range(0, 3);
            case (op)
               0: begin
                  press(3'b001);
                  m_fld = (m_fld + 1) % 3;
               end
               1: begin
                  press(3'b010);
                  m_val[m_fld] = (m_val[m_fld] + 1) % (m_max[m_fld] + 1);
               end
               2: begin
                  press(3'b100);
                  m_val[m_fld] = (m_val[m_fld] + m_max[m_fld]) %
                                 (m_max[m_fld] + 1);
               end
               default: press(3'b110);
            endcase
         end
         n_checks++;
         if (field !== sel_of(m_fld))
            $display("FAIL random field it=%0d: got %b, required %b", it,
                     field, sel_of(m_fld));
         else n_pass++;
         submit_expect($sformatf("rand%0d", it), m_val[0], m_val[1], m_val[2]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_inc_dec_same();
      test_clamp();
      test_abort();
      test_hold();
      test_reset_mid_write();
      test_reenter();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
